// File: rtl/lcd_timing_receiver.sv
// RGB LCD timing receiver: samples hs/vs/den/rgb on pclk, recovers pixel
// coordinates, measures frame geometry and reports lock once timing is stable.
// Ports:
//   pclk, rst            - pixel clock, synchronous active-high reset
//   hs, vs, den, rgb     - incoming video (hs/vs active-low, den active-high)
//   pixel_valid/x/y/data - captured pixel stream, 2 pclk latency
//   frame_start          - pulse on each detected vs falling edge
//   h_total, v_total     - last measured pclks per line / lines per frame
//   h_active, v_active   - last measured active pixels per line / active lines
//   locked, mismatch     - lock status and per-frame compare-failure pulse
//   frame_checksum       - only with LCD_RX_CHECKSUM_EN: mod 2^24 pixel sum
// Optional macro: LCD_RX_CHECKSUM_EN

module lcd_timing_receiver #(
   parameter int unsigned LOCK_FRAMES    = 2,
   parameter int unsigned EXP_H_ACTIVE   = 750,
   parameter int unsigned EXP_V_ACTIVE   = 1334,
   parameter int unsigned CHECK_EXPECTED = 0
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        hs,
   input  logic        vs,
   input  logic        den,
   input  logic [23:0] rgb,
   output logic        pixel_valid,
   output logic [10:0] pixel_x,
   output logic [10:0] pixel_y,
   output logic [23:0] pixel_data,
   output logic        frame_start,
   output logic [10:0] h_total,
   output logic [10:0] v_total,
   output logic [10:0] h_active,
   output logic [10:0] v_active,
   output logic        locked,
   output logic        mismatch
`ifdef LCD_RX_CHECKSUM_EN
   ,
   output logic [23:0] frame_checksum
`endif
);

   localparam logic [10:0] EXP_H  = 11'(EXP_H_ACTIVE);
   localparam logic [10:0] EXP_V  = 11'(EXP_V_ACTIVE);
   localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);
   localparam logic [10:0] CMAX   = 11'h7FF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MEASURE,
      ST_TRACK,
      ST_LOCKED
   } state_e;

   function automatic logic [10:0] sat_inc(input logic [10:0] v);
      return (v == CMAX) ? v : v + 11'd1;
   endfunction

   // ------------------------------------------------------------------
   // Input stage: one capture register plus one delay for edge detect
   // ------------------------------------------------------------------
   logic        s_hs_q, s_vs_q, s_den_q;
   logic [23:0] s_rgb_q;
   logic        d_hs_q, d_vs_q, d_den_q;

   logic hs_fall, vs_fall, den_fall;

   assign hs_fall  = d_hs_q & ~s_hs_q;
   assign vs_fall  = d_vs_q & ~s_vs_q;
   assign den_fall = d_den_q & ~s_den_q;

   // ------------------------------------------------------------------
   // State and counters
   // ------------------------------------------------------------------
   state_e      state_q;
   logic [3:0]  match_cnt_q;

   logic [10:0] pcnt_q, pcnt_d;
   logic [10:0] x_q, x_d;
   logic [10:0] y_q, y_d;
   logic [10:0] line_q, line_d;

   // First-line reference of the frame being measured
   logic        rht_vld_q, rht_vld_d;
   logic [10:0] rht_q, rht_d;
   logic        rha_vld_q, rha_vld_d;
   logic [10:0] rha_q, rha_d;
   logic        incons_q, incons_d;

   logic        pix_stb;
   logic [10:0] htot_new;
   logic        ht_bad, ha_bad, incons_now;
   logic [10:0] fr_htot, fr_vtot, fr_hact, fr_vact;
   logic        exp_ok, frame_ok;
   logic [3:0]  match_inc;

   assign pix_stb  = s_den_q & (state_q != ST_IDLE);
   assign htot_new = sat_inc(pcnt_q);

   // An hs/den fall coinciding with vs fall closes the last line of the
   // outgoing frame, so it is folded into that frame's verdict here.
   assign ht_bad     = hs_fall & rht_vld_q & (htot_new != rht_q);
   assign ha_bad     = den_fall & rha_vld_q & (x_q != rha_q);
   assign incons_now = incons_q | ht_bad | ha_bad;

   assign fr_htot = rht_vld_q ? rht_q : (hs_fall ? htot_new : 11'd0);
   assign fr_hact = rha_vld_q ? rha_q : (den_fall ? x_q : 11'd0);
   assign fr_vtot = line_q;
   assign fr_vact = y_q;

   assign exp_ok = (CHECK_EXPECTED == 0) ||
                   ((fr_hact == EXP_H) && (fr_vact == EXP_V));

   assign frame_ok = (fr_htot == h_total)  &&
                     (fr_vtot == v_total)  &&
                     (fr_hact == h_active) &&
                     (fr_vact == v_active) &&
                     !incons_now && exp_ok;

   assign match_inc = match_cnt_q + 4'd1;

   always_comb begin
      pcnt_d = hs_fall ? 11'd0 : sat_inc(pcnt_q);

      x_d = x_q;
      if (den_fall) begin
         x_d = 11'd0;
      end else if (pix_stb) begin
         x_d = sat_inc(x_q);
      end

      // vs fall wins over a simultaneous den fall
      y_d = y_q;
      if (vs_fall) begin
         y_d = 11'd0;
      end else if (den_fall) begin
         y_d = sat_inc(y_q);
      end

      line_d = line_q;
      if (vs_fall) begin
         line_d = hs_fall ? 11'd1 : 11'd0;
      end else if (hs_fall) begin
         line_d = sat_inc(line_q);
      end

      rht_vld_d = rht_vld_q;
      rht_d     = rht_q;
      rha_vld_d = rha_vld_q;
      rha_d     = rha_q;
      incons_d  = incons_now;
      if (vs_fall) begin
         rht_vld_d = 1'b0;
         rht_d     = 11'd0;
         rha_vld_d = 1'b0;
         rha_d     = 11'd0;
         incons_d  = 1'b0;
      end else begin
         if (hs_fall && !rht_vld_q) begin
            rht_vld_d = 1'b1;
            rht_d     = htot_new;
         end
         if (den_fall && !rha_vld_q) begin
            rha_vld_d = 1'b1;
            rha_d     = x_q;
         end
      end
   end

`ifdef LCD_RX_CHECKSUM_EN
   logic [23:0] acc_q, acc_d, sum_now;

   assign sum_now = acc_q + (pix_stb ? s_rgb_q : 24'd0);
   assign acc_d   = vs_fall ? 24'd0 : sum_now;

   always_ff @(posedge pclk) begin
      if (rst) begin
         acc_q          <= 24'd0;
         frame_checksum <= 24'd0;
      end else begin
         acc_q <= acc_d;
         if (vs_fall) begin
            frame_checksum <= sum_now;
         end
      end
   end
`endif

   // ------------------------------------------------------------------
   // Registers, pixel path and lock FSM
   // ------------------------------------------------------------------
   always_ff @(posedge pclk) begin
      if (rst) begin
         s_hs_q      <= 1'b0;
         s_vs_q      <= 1'b0;
         s_den_q     <= 1'b0;
         s_rgb_q     <= 24'd0;
         d_hs_q      <= 1'b0;
         d_vs_q      <= 1'b0;
         d_den_q     <= 1'b0;
         pcnt_q      <= 11'd0;
         x_q         <= 11'd0;
         y_q         <= 11'd0;
         line_q      <= 11'd0;
         rht_vld_q   <= 1'b0;
         rht_q       <= 11'd0;
         rha_vld_q   <= 1'b0;
         rha_q       <= 11'd0;
         incons_q    <= 1'b0;
         state_q     <= ST_IDLE;
         match_cnt_q <= 4'd0;
         pixel_valid <= 1'b0;
         pixel_x     <= 11'd0;
         pixel_y     <= 11'd0;
         pixel_data  <= 24'd0;
         frame_start <= 1'b0;
         h_total     <= 11'd0;
         v_total     <= 11'd0;
         h_active    <= 11'd0;
         v_active    <= 11'd0;
         locked      <= 1'b0;
         mismatch    <= 1'b0;
      end else begin
         s_hs_q    <= hs;
         s_vs_q    <= vs;
         s_den_q   <= den;
         s_rgb_q   <= rgb;
         d_hs_q    <= s_hs_q;
         d_vs_q    <= s_vs_q;
         d_den_q   <= s_den_q;
         pcnt_q    <= pcnt_d;
         x_q       <= x_d;
         y_q       <= y_d;
         line_q    <= line_d;
         rht_vld_q <= rht_vld_d;
         rht_q     <= rht_d;
         rha_vld_q <= rha_vld_d;
         rha_q     <= rha_d;
         incons_q  <= incons_d;

         pixel_valid <= pix_stb;
         if (pix_stb) begin
            pixel_x    <= x_q;
            pixel_y    <= y_q;
            pixel_data <= s_rgb_q;
         end

         frame_start <= vs_fall;
         mismatch    <= 1'b0;

         if (vs_fall) begin
            if (state_q != ST_IDLE) begin
               h_total  <= fr_htot;
               v_total  <= fr_vtot;
               h_active <= fr_hact;
               v_active <= fr_vact;
            end
            unique case (state_q)
               ST_IDLE: begin
                  state_q <= ST_MEASURE;
               end
               ST_MEASURE: begin
                  state_q     <= ST_TRACK;
                  match_cnt_q <= 4'd0;
               end
               ST_TRACK: begin
                  if (frame_ok) begin
                     match_cnt_q <= match_inc;
                     if (match_inc >= LOCK_N) begin
                        state_q <= ST_LOCKED;
                        locked  <= 1'b1;
                     end
                  end else begin
                     mismatch    <= 1'b1;
                     match_cnt_q <= 4'd0;
                  end
               end
               ST_LOCKED: begin
                  if (!frame_ok) begin
                     mismatch    <= 1'b1;
                     locked      <= 1'b0;
                     match_cnt_q <= 4'd0;
                     state_q     <= ST_TRACK;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: doc/lcd_timing_receiver.md
Name: lcd_timing_receiver

Overview:
- Sink-side counterpart of the RGB LCD timing generator. Samples parallel RGB video (hs, vs, den, rgb) on rising pclk.
- Recovers per-pixel coordinates, measures frame geometry and reports lock once timing is stable.
- Used as a loopback checker and capture front-end for the RGB/SSD2828 path. Feeds frame buffers or test monitors.

Parameters:
- LOCK_FRAMES, 2, consecutive matching frame measurements required to assert locked (1..15).
- EXP_H_ACTIVE, 750, expected active pixels per line (used only when CHECK_EXPECTED=1).
- EXP_V_ACTIVE, 1334, expected active lines per frame (used only when CHECK_EXPECTED=1).
- CHECK_EXPECTED, 0, 1 = a frame also counts as a match only if its active sizes equal EXP_*.

Ports:
- pclk  in  1  pixel clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- hs  in  1  horizontal sync, active-low
- vs  in  1  vertical sync, active-low
- den  in  1  data enable, active-high
- rgb  in  24  pixel data
- pixel_valid  out  1  output pixel strobe
- pixel_x  out  11  active column of output pixel
- pixel_y  out  11  active row of output pixel
- pixel_data  out  24  captured rgb
- frame_start  out  1  1-cycle pulse on detected vs falling edge
- h_total  out  11  last measured pclks per line
- v_total  out  11  last measured lines per frame
- h_active  out  11  last measured den-high pixels per line
- v_active  out  11  last measured lines containing den
- locked  out  1  timing stable
- mismatch  out  1  1-cycle pulse when a compared frame differs

Behaviour:
- Reset: all outputs 0 and all counters 0. State IDLE. Reset mid-frame discards partial measurements.
- Input stage: hs, vs, den and rgb are registered once (s_*) and delayed once more (d_*). Edges are taken from s_* vs d_*.
- Pixel path: if s_den=1 and state≠IDLE, the next edge outputs pixel_valid=1 with pixel_data=s_rgb and the current x/y. Fixed latency is 2 rising edges from input to output.
- x counter: increments per valid pixel. Clears on den falling edge.
- y counter: increments on den falling edge. Clears on vs falling edge.
- Counters saturate at 2047 and never wrap.
- Line measurement:
  - pclk counter restarts at 0 on each hs falling edge; on that edge h_total_cur = count+1.
  - h_active_cur = pixel count at den falling edge.
  - If any line in the frame has an h_total_cur or h_active_cur different from the frame's first line, the frame is flagged inconsistent.
- Frame measurement: line counter increments on hs falling edge. On vs falling edge the completed frame's values are latched to the h_total/v_total/h_active/v_active outputs.
- Simultaneous events:
  - vs and hs fall in the same cycle: both are processed, and the line counter restarts at 1.
  - den falling edge and vs falling edge in the same cycle: y clears, so vs wins.
- States (all transitions evaluated on vs falling edge, which also pulses frame_start):
  - IDLE -> MEASURE on first vs fall. No latch.
  - MEASURE -> TRACK on next vs fall. Latch first frame; no compare.
  - TRACK: compare the new frame to the previously latched one.
    - Match (all four equal, not inconsistent, EXP_* satisfied if checked): match_cnt+1.
    - On match_cnt reaching LOCK_FRAMES, go to LOCKED with locked=1.
    - Mismatch: pulse mismatch, match_cnt=0.
  - LOCKED: compare each frame the same way.
    - Mismatch: locked=0 the next cycle, mismatch pulse, match_cnt=0, go to TRACK.
- Values are always latched, even when the frame mismatches.

Optional Feature:
- Macro: LCD_RX_CHECKSUM_EN.
- With the macro defined:
  - Adds output frame_checksum [23:0]: the modulo 2^24 sum of pixel_data over all valid pixels of the completed frame.
  - Latched on vs falling edge; accumulator cleared in the same cycle.
  - Reset value 0.
- Without the macro: the port and its logic are absent.

Test Plan:
- Reset: hold rst=1 for 5 cycles with toggling inputs -> all outputs 0, no frame_start.
- Geometry: drive timing H sync2/bp3/act4/fp5 and V sync2/bp3/act4/fp5 (14x14) -> after 2nd vs fall h_total=14, v_total=14, h_active=4, v_active=4. With LOCK_FRAMES=2, locked=1 after 4th vs fall.
- Pixels: rgb = {y,x} pattern -> exactly 16 pixel_valid per frame, first (0,0), last (3,3), data matches the input delayed 2 edges.
- Mismatch: while locked, change H active to 5 for one frame -> mismatch pulse and locked=0 at the next vs fall, h_active=5. Relock after 2 further matching frames.
- Mid-frame reset: assert rst at line 7 -> outputs clear, state IDLE. The first frame_start occurs only at the next vs fall, with no pixel_valid before it.
- Checksum (macro on): constant rgb 24'h00FF00 in the 14x14 timing -> frame_checksum=24'h0FF000 on every vs fall after the first full frame.
